// File: rtl/multicycle_alu.sv
// multicycle_alu -- registered execute-stage ALU with iterative multiply/divide.
//
// Single-cycle ops (and/or/add/sub/slt/nor) register their result into aluout
// and pulse done one cycle after start. multu/divu run one bit per cycle for
// WIDTH cycles with busy high, then pulse done from the FIN state with the
// final {hi,lo}.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   aluin1, aluin2      operands A and B (sampled with an accepted start)
//   aluctl              operation select (sampled with an accepted start)
//   start               launch; only accepted in IDLE
//   aluout              registered single-cycle result
//   zero, overflow      registered A==B and signed add/sub overflow
//   busy                multiply/divide in progress
//   done                one-cycle result-valid pulse
//   hi, lo              product high/low, or remainder/quotient
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] aluin1,
    input  logic [WIDTH-1:0] aluin2,
    input  logic [3:0]       aluctl,
    input  logic             start,
    output logic [WIDTH-1:0] aluout,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] aluout_q, hi_q, lo_q;
    logic             zero_q, ovf_q, done_q;

    logic             accept, is_mul, is_div, last_iter;
    logic [WIDTH-1:0] add_res, sub_res, sc_res;
    logic             sc_ovf;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ok;

    assign accept    = (state_q == S_IDLE) && start;
    assign is_mul    = (aluctl == OP_MULU);
    assign is_div    = (aluctl == OP_DIVU);
    assign last_iter = (cnt_q == CNTW'(WIDTH - 1));

    // Single-cycle datapath works straight off the inputs; it is only
    // consumed on the accepting edge.
    assign add_res = aluin1 + aluin2;
    assign sub_res = aluin1 - aluin2;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (aluctl)
            OP_AND: sc_res = aluin1 & aluin2;
            OP_OR:  sc_res = aluin1 | aluin2;
            OP_ADD: begin
                sc_res = add_res;
                sc_ovf = (aluin1[WIDTH-1] == aluin2[WIDTH-1]) &&
                         (add_res[WIDTH-1] != aluin1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_res;
                sc_ovf = (aluin1[WIDTH-1] != aluin2[WIDTH-1]) &&
                         (sub_res[WIDTH-1] != aluin1[WIDTH-1]);
            end
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(aluin1) < $signed(aluin2))};
            OP_NOR: sc_res = ~(aluin1 | aluin2);
            default: sc_res = '0;
        endcase
    end

    // Right-shifting multiply: add multiplicand into hi when the current
    // multiplier LSB is set, then shift the whole {hi,lo} pair right.
    assign mul_sum = {1'b0, hi_q} + {1'b0, (b_q[0] ? a_q : '0)};

    // Restoring divide: lo starts as the dividend and fills with quotient
    // bits from the right; hi carries the partial remainder. A zero divisor
    // always "fits", giving an all-ones quotient and remainder == A.
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, b_q});
    assign div_diff  = div_shift - {1'b0, b_q};

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && is_mul)      state_d = S_MUL;
                    else if (accept && is_div) state_d = S_DIV;
            S_MUL,
            S_DIV:  if (last_iter) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == S_MUL) || (state_q == S_DIV);
        done = done_q || (state_q == S_FIN);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    zero_q <= (aluin1 == aluin2);
                    ovf_q  <= sc_ovf;
                    a_q    <= aluin1;
                    b_q    <= aluin2;
                    cnt_q  <= '0;
                    if (is_mul) begin
                        hi_q <= '0;
                        lo_q <= '0;
                    end else if (is_div) begin
                        hi_q <= '0;
                        lo_q <= aluin1;
                    end else begin
                        aluout_q <= sc_res;
                        done_q   <= 1'b1;
                    end
                end
                S_MUL: begin
                    {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
                    b_q          <= b_q >> 1;
                    cnt_q        <= cnt_q + CNTW'(1);
                end
                S_DIV: begin
                    hi_q  <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    lo_q  <= {lo_q[WIDTH-2:0], div_ok};
                    cnt_q <= cnt_q + CNTW'(1);
                end
                default: ;
            endcase
        end
    end

    assign aluout   = aluout_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;
    localparam int W = 32;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W - 1));

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic [3:0]   ctl = '0;
    logic         start = 1'b0;
    logic [W-1:0] aluout, hi, lo;
    logic         zero, overflow, busy, done;

    multicycle_alu #(.WIDTH(W), .CNTW(6)) dut (
        .clk(clk), .reset(reset), .aluin1(a), .aluin2(b), .aluctl(ctl),
        .start(start), .aluout(aluout), .zero(zero), .overflow(overflow),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] aluout, hi, lo;
        logic         zero, ovf;
        int           exp_cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0;
    logic [W-1:0] m_aluout = '0, m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on wide integers.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        longint sx, sy, r;
        longint unsigned p;
        bit iter;
        @(negedge clk);
        ctl = op; a = x; b = y; start = 1'b1;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        iter = (op == 4'b1000) || (op == 4'b1001);
        e.zero = (x == y);
        e.ovf  = 1'b0;
        case (op)
            4'b0000: m_aluout = x & y;
            4'b0001: m_aluout = x | y;
            4'b0010: begin r = sx + sy; m_aluout = W'(r); e.ovf = (r > SMAX) || (r < SMIN); end
            4'b0110: begin r = sx - sy; m_aluout = W'(r); e.ovf = (r > SMAX) || (r < SMIN); end
            4'b0111: m_aluout = (sx < sy) ? 1 : 0;
            4'b1100: m_aluout = ~(x | y);
            4'b1000: begin
                p = longint'(x) * longint'(y);
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            4'b1001: begin
                if (y == 0) begin m_lo = '1; m_hi = x; end
                else begin m_lo = x / y; m_hi = x % y; end
            end
            default: m_aluout = '0;
        endcase
        e.aluout  = m_aluout;
        e.hi      = m_hi;
        e.lo      = m_lo;
        e.exp_cyc = cyc + 1 + (iter ? W : 0);
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.exp_cyc);
                chk("aluout", aluout, e.aluout);
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("zero", zero, e.zero);
                chk("overflow", overflow, e.ovf);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [10];
        int nb;
        ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h8, 4'h9, 4'h3, 4'hF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_aluout", aluout, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_zero", zero, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;

        // Basic single-cycle ops, back to back
        issue(4'b0010, 5, 7);
        issue(4'b0110, 9, 9);
        idle(); drain();

        // Overflow and signed boundaries
        issue(4'b0010, 32'h7FFF_FFFF, 1);
        issue(4'b0110, 32'h8000_0000, 1);
        issue(4'b0111, 32'hFFFF_FFFF, 1);
        issue(4'b1100, 0, 0);
        idle(); drain();

        // multu with busy-length check
        issue(4'b1000, 32'hFFFF_FFFF, 2);
        idle();
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) nb++;
            if (done) break;
            @(negedge clk);
        end
        chk("mul_busy_cycles", nb, W);
        drain();

        // divu, including divide by zero
        issue(4'b1001, 100, 7);
        idle(); drain();
        issue(4'b1001, 32'h1234, 0);
        idle(); drain();

        // multu with an ignored start at t+5
        issue(4'b1000, 3, 4);
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk) begin ctl = 4'b0010; a = 1; b = 1; start = 1'b1; end
        @(negedge clk) start = 1'b0;
        drain();
        chk("ignored_start_zero", zero, 0);

        // Reset in the middle of a divu aborts it
        @(negedge clk) begin ctl = 4'b1001; a = 32'hDEAD; b = 3; start = 1'b1; end
        @(negedge clk) start = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        m_aluout = '0; m_hi = '0; m_lo = '0;
        repeat (40) @(negedge clk);
        issue(4'b0010, 1, 1);
        idle(); drain();

        // Randomized mix
        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            logic [W-1:0] x, y;
            op = ops[$urandom_range(0, 9)];
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? x : $urandom;
            if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) y = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h7FFF_FFFF;
            issue(op, x, y);
            if (op == 4'b1000 || op == 4'b1001) begin
                idle(); drain();
            end
        end
        idle(); drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
